pe_pipe: RTL and testbench

//  Parametrised, pipelined processing element for the non-von-Neumann PE mesh. It holds a locally loaded

---
 rtl/pe_pipe.sv | 187 ++++++++++++++++++
 tb/tb_pe_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_pipe.sv
// rtl/pe_pipe.sv - two-stage pipelined PE: config-selected operand mux, ALU/accumulate, self-feedback
// Optional feature macro: PE_SAT_EN (saturating ADD/ACC, clamping SUB); undefined = modulo wrap.

module pe_pipe #(
    parameter int WIDTH = 4,
    parameter int N_NBR = 4,
    localparam int SEL_W = $clog2(N_NBR + 3),
    localparam int SH_W  = $clog2(WIDTH),
    localparam int CFG_W = 3 + 2 * SEL_W
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   en,
    input  logic                   clear,
    input  logic                   cfg_load,
    input  logic [CFG_W-1:0]       cfg_in,
    input  logic [N_NBR*WIDTH-1:0] nbr_in,
    input  logic [WIDTH-1:0]       op_in0,
    input  logic [WIDTH-1:0]       op_in1,
    input  logic                   in_valid,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid
);

    localparam logic [2:0] OP_OR  = 3'd0;
    localparam logic [2:0] OP_NOT = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_ACC = 3'd7;

    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [2:0]       cfg_op;
    logic [SEL_W-1:0] cfg_sel0;
    logic [SEL_W-1:0] cfg_sel1;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;

    assign {cfg_op, cfg_sel0, cfg_sel1} = cfg_q;

    // Source order: neighbours, op_in0, op_in1, own registered output; anything beyond selects 0.
    function automatic logic [WIDTH-1:0] pick_src(
        input logic [SEL_W-1:0]       sel,
        input logic [N_NBR*WIDTH-1:0] nbr,
        input logic [WIDTH-1:0]       ext0,
        input logic [WIDTH-1:0]       ext1,
        input logic [WIDTH-1:0]       fb
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N_NBR; k++) begin
            if (int'(sel) == k) begin
                r = nbr[k*WIDTH +: WIDTH];
            end
        end
        if (int'(sel) == N_NBR) begin
            r = ext0;
        end
        if (int'(sel) == N_NBR + 1) begin
            r = ext1;
        end
        if (int'(sel) == N_NBR + 2) begin
            r = fb;
        end
        return r;
    endfunction

    always_comb begin
        src_a = pick_src(cfg_sel0, nbr_in, op_in0, op_in1, out_q);
        src_b = pick_src(cfg_sel1, nbr_in, op_in0, op_in1, out_q);
    end

    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH:0]    acc_ext;
    logic [WIDTH-1:0]  add_res;
    logic [WIDTH-1:0]  sub_res;
    logic [WIDTH-1:0]  acc_res;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  alu_res;

    always_comb begin
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        diff_ext = {1'b0, a_q} - {1'b0, b_q};
        acc_ext  = {1'b0, acc_q} + {1'b0, a_q};
        shamt    = b_q[SH_W-1:0];
`ifdef PE_SAT_EN
        add_res  = sum_ext[WIDTH]  ? '1 : sum_ext[WIDTH-1:0];
        sub_res  = diff_ext[WIDTH] ? '0 : diff_ext[WIDTH-1:0];
        acc_res  = acc_ext[WIDTH]  ? '1 : acc_ext[WIDTH-1:0];
`else
        add_res  = sum_ext[WIDTH-1:0];
        sub_res  = diff_ext[WIDTH-1:0];
        acc_res  = acc_ext[WIDTH-1:0];
`endif
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_OR:   alu_res = a_q | b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_SLL:  alu_res = a_q << shamt;
            OP_SRL:  alu_res = a_q >> shamt;
            OP_ADD:  alu_res = add_res;
            OP_SUB:  alu_res = sub_res;
            OP_ACC:  alu_res = acc_res;
            default: alu_res = '0;
        endcase
    end

    // Stage 1 samples with the config as it stands this cycle; a load only steers later beats.
    always_comb begin
        cfg_d       = cfg_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        v1_d        = v1_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        if (en) begin
            if (clear) begin
                cfg_d       = '0;
                a_d         = '0;
                b_d         = '0;
                op_d        = '0;
                v1_d        = 1'b0;
                out_d       = '0;
                out_valid_d = 1'b0;
                acc_d       = '0;
            end else begin
                if (cfg_load) begin
                    cfg_d = cfg_in;
                end
                a_d  = src_a;
                b_d  = src_b;
                op_d = cfg_op;
                v1_d = in_valid;
                out_valid_d = v1_q;
                if (v1_q) begin
                    out_d = alu_res;
                    if (op_q == OP_ACC) begin
                        acc_d = acc_res;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cfg_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            v1_q        <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            cfg_q       <= cfg_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            v1_q        <= v1_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pe_pipe.sv
// tb/tb_pe_pipe.sv - randomized and directed checks of pe_pipe against a queue-based reference model

module tb_pe_pipe;

    localparam int W     = 4;
    localparam int N     = 4;
    localparam int SEL_W = 3;
    localparam int CFG_W = 3 + 2 * SEL_W;
    localparam int MASK  = (1 << W) - 1;
`ifdef PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_l;
    logic             en;
    logic             clear;
    logic             cfg_load;
    logic [CFG_W-1:0] cfg_in;
    logic [N*W-1:0]   nbr_in;
    logic [W-1:0]     op_in0;
    logic [W-1:0]     op_in1;
    logic             in_valid;
    logic [W-1:0]     out;
    logic             out_valid;

    pe_pipe #(.WIDTH(W), .N_NBR(N)) dut (
        .clk(clk), .rst_l(rst_l), .en(en), .clear(clear), .cfg_load(cfg_load),
        .cfg_in(cfg_in), .nbr_in(nbr_in), .op_in0(op_in0), .op_in1(op_in1),
        .in_valid(in_valid), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit v;
        int a;
        int b;
        int op;
    } beat_t;

    beat_t pipe_q[$];
    int    m_op, m_sel0, m_sel1;
    int    m_out, m_ov, m_acc;
    int    nbr_v[N];

    function automatic int sat_or_wrap_add(int x, int y);
        int s = x + y;
        if (SAT) return (s > MASK) ? MASK : s;
        return s % (MASK + 1);
    endfunction

    function automatic int sat_or_wrap_sub(int x, int y);
        if (SAT) return (x < y) ? 0 : x - y;
        return (x - y + MASK + 1) % (MASK + 1);
    endfunction

    function automatic int alu_ref(int op, int a, int b, int acc);
        case (op)
            0: return a | b;
            1: return (~a) & MASK;
            2: return a & b;
            3: return (a << (b % W)) & MASK;
            4: return a >> (b % W);
            5: return sat_or_wrap_add(a, b);
            6: return sat_or_wrap_sub(a, b);
            default: return sat_or_wrap_add(acc, a);
        endcase
    endfunction

    function automatic int src_ref(int sel);
        if (sel < N)      return nbr_v[sel];
        if (sel == N)     return int'(op_in0);
        if (sel == N + 1) return int'(op_in1);
        if (sel == N + 2) return m_out;
        return 0;
    endfunction

    function automatic logic [CFG_W-1:0] mk_cfg(int op, int s0, int s1);
        return {3'(op), 3'(s0), 3'(s1)};
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        m_op = 0; m_sel0 = 0; m_sel1 = 0;
        m_out = 0; m_ov = 0; m_acc = 0;
    endtask

    task automatic model_edge();
        beat_t s, p;
        int r;
        if (!en) return;
        if (clear) begin
            model_reset();
            return;
        end
        s.v  = in_valid;
        s.a  = src_ref(m_sel0);
        s.b  = src_ref(m_sel1);
        s.op = m_op;
        m_ov = 0;
        if (pipe_q.size() > 0) begin
            p = pipe_q.pop_front();
            if (p.v) begin
                r = alu_ref(p.op, p.a, p.b, m_acc);
                m_out = r;
                m_ov  = 1;
                if (p.op == 7) m_acc = r;
            end
        end
        pipe_q.push_back(s);
        if (cfg_load) begin
            m_op   = int'(cfg_in[8:6]);
            m_sel0 = int'(cfg_in[5:3]);
            m_sel1 = int'(cfg_in[2:0]);
        end
    endtask

    task automatic set_nbr(int n0, int n1, int n2, int n3);
        nbr_v[0] = n0; nbr_v[1] = n1; nbr_v[2] = n2; nbr_v[3] = n3;
        for (int k = 0; k < N; k++) nbr_in[k*W +: W] = W'(nbr_v[k]);
    endtask

    task automatic set_in(bit e, bit c, bit l, logic [CFG_W-1:0] cfg, bit v, int o0, int o1);
        en = e; clear = c; cfg_load = l; cfg_in = cfg; in_valid = v;
        op_in0 = W'(o0); op_in1 = W'(o1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("out", out, m_out);
        check("out_valid", out_valid, m_ov);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        model_reset();
        #1;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic one_beat(logic [CFG_W-1:0] cfg, int o0, int o1);
        set_in(1, 0, 1, cfg, 0, o0, o1); step();
        set_in(1, 0, 0, cfg, 1, o0, o1); step();
        set_in(1, 0, 0, cfg, 0, o0, o1); step();
    endtask

    int acc_exp[4];
    int got_seq[$];

    initial begin
        rst_l = 1'b1;
        set_nbr(0, 0, 0, 0);
        set_in(0, 0, 0, '0, 0, 0, 0);
        #2;
        do_reset();

        // 1: ADD of external operands wraps (or saturates)
        one_beat(mk_cfg(5, 4, 5), 9, 8);
        check("t1_add", out, SAT ? 15 : 1);
        check("t1_valid", out_valid, 1);

        // 2: shifts via neighbours, then out-of-range select reads zero
        set_nbr(3, 6, 0, 0);
        one_beat(mk_cfg(3, 0, 1), 0, 0);
        check("t2_sll", out, 12);
        one_beat(mk_cfg(4, 0, 1), 0, 0);
        check("t2_srl", out, 0);
        one_beat(mk_cfg(0, 7, 1), 0, 0);
        check("t2_sel_oor", out, 6);

        // 3: accumulate four beats, then clear
        acc_exp = SAT ? '{5, 10, 15, 15} : '{5, 10, 15, 4};
        set_in(1, 1, 0, '0, 0, 0, 0); step();
        set_in(1, 0, 1, mk_cfg(7, 4, 5), 0, 5, 0); step();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, '0, 1, 5, 0); step();
            if (i >= 1) check("t3_acc", out, acc_exp[i-1]);
        end
        set_in(1, 0, 0, '0, 0, 5, 0); step();
        check("t3_acc_last", out, acc_exp[3]);
        set_in(1, 1, 0, '0, 1, 5, 0); step();
        check("t3_clear_out", out, 0);
        check("t3_clear_valid", out_valid, 0);
        one_beat(mk_cfg(7, 4, 5), 5, 0);
        check("t3_acc_after_clear", out, 5);

        // 5: config load in the same cycle as a beat
        set_in(1, 0, 1, mk_cfg(0, 4, 5), 0, 10, 6); step();
        set_in(1, 0, 1, mk_cfg(2, 4, 5), 1, 10, 6); step();
        set_in(1, 0, 0, '0, 1, 10, 6); step();
        check("t5_old_or", out, 14);
        set_in(1, 0, 0, '0, 0, 10, 6); step();
        check("t5_new_and", out, 2);

        // 4: stream with a two-cycle freeze in the middle
        got_seq.delete();
        set_in(1, 0, 1, mk_cfg(5, 4, 5), 0, 0, 1); step();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: set_in(1, 0, 0, '0, 1, 1, 1);
                1: set_in(1, 0, 0, '0, 1, 2, 1);
                2, 3: set_in(0, 0, 0, '0, 1, 9, 9);
                4: set_in(1, 0, 0, '0, 1, 3, 1);
                default: set_in(1, 0, 0, '0, 0, 0, 1);
            endcase
            step();
            if (en && out_valid) got_seq.push_back(int'(out));
        end
        check("t4_count", got_seq.size(), 3);
        for (int i = 0; i < 3 && i < got_seq.size(); i++) check("t4_order", got_seq[i], i + 2);

        // 6: reset with two beats in flight
        set_in(1, 0, 0, '0, 1, 4, 4); step();
        set_in(1, 0, 0, '0, 1, 5, 5); step();
        do_reset();
        set_in(1, 0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_stale", out_valid, 0);
        end
        set_nbr(5, 0, 0, 0);
        set_in(1, 0, 0, '0, 1, 0, 0); step();
        set_in(1, 0, 0, '0, 0, 0, 0); step();
        check("t6_cfg_zero", out, 5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_nbr($urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK));
            set_in($urandom_range(9) != 0, $urandom_range(39) == 0, $urandom_range(5) == 0,
                   mk_cfg($urandom_range(7), $urandom_range(7), $urandom_range(7)),
                   $urandom_range(9) < 6, $urandom_range(MASK), $urandom_range(MASK));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
